pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_hazard_detect.sv | 21 ++
 rtl/pipe_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: hold levels, FSM states and widths.
package pipe_ctrl_pkg;

    localparam int unsigned HOLD_FLAG_BUS  = 3;
    localparam int unsigned REG_ADDR_W     = 5;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned STALL_CNT_W    = 32;
    localparam int unsigned REDIRECT_CNT_W = 16;

    typedef enum logic [HOLD_FLAG_BUS-1:0] {
        HOLD_NONE = 3'd0,
        HOLD_PC   = 3'd1,
        HOLD_IF   = 3'd2,
        HOLD_ID   = 3'd3
    } hold_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        DIV_WAIT = 2'd2,
        INT_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection between the load in EX and the source operands in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  ex_load_i,
    input  logic                  ex_reg_we_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_re_i,
    input  logic                  id_rs2_re_i,
    output logic                  load_use_o
);

    always_comb begin
        load_use_o = ex_load_i && ex_reg_we_i && (ex_rd_i != '0) &&
                     ((id_rs1_re_i && (id_rs1_i == ex_rd_i)) ||
                      (id_rs2_re_i && (id_rs2_i == ex_rd_i)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates redirects, multi-cycle holds and load-use bubbles,
// and counts stall and redirect cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      jump_flag_i,
    input  logic [ADDR_W-1:0]         jump_addr_i,
    input  logic                      div_start_i,
    input  logic                      div_done_i,
    input  logic                      ex_load_i,
    input  logic                      ex_reg_we_i,
    input  logic [REG_ADDR_W-1:0]     ex_rd_i,
    input  logic [REG_ADDR_W-1:0]     id_rs1_i,
    input  logic [REG_ADDR_W-1:0]     id_rs2_i,
    input  logic                      id_rs1_re_i,
    input  logic                      id_rs2_re_i,
    input  logic                      int_hold_req_i,
    input  logic                      int_assert_i,
    input  logic [ADDR_W-1:0]         int_addr_i,
    input  logic                      bus_hold_req_i,
    output logic [HOLD_FLAG_BUS-1:0]  hold_flag_o,
    output logic                      stall_pc_o,
    output logic                      stall_if_id_o,
    output logic                      stall_id_ex_o,
    output logic                      flush_if_id_o,
    output logic                      flush_id_ex_o,
    output logic                      jump_flag_o,
    output logic [ADDR_W-1:0]         jump_addr_o,
    output logic [STALL_CNT_W-1:0]    stall_cnt_o,
    output logic [REDIRECT_CNT_W-1:0] redirect_cnt_o
);

    state_e                    state_q, state_d;
    hold_e                     hold;
    logic                      load_use;
    logic                      any_stall;
    logic [STALL_CNT_W-1:0]    stall_cnt_q;
    logic [REDIRECT_CNT_W-1:0] redirect_cnt_q;

    hazard_detect u_hazard_detect (
        .ex_load_i   (ex_load_i),
        .ex_reg_we_i (ex_reg_we_i),
        .ex_rd_i     (ex_rd_i),
        .id_rs1_i    (id_rs1_i),
        .id_rs2_i    (id_rs2_i),
        .id_rs1_re_i (id_rs1_re_i),
        .id_rs2_re_i (id_rs2_re_i),
        .load_use_o  (load_use)
    );

    always_comb begin
        state_d       = state_q;
        hold          = HOLD_NONE;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        jump_flag_o   = 1'b0;
        jump_addr_o   = '0;
        unique case (state_q)
            RUN: begin
                if (jump_flag_i) begin
                    jump_flag_o   = 1'b1;
                    jump_addr_o   = jump_addr_i;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    state_d       = FLUSH;
                end else if (int_hold_req_i) begin
                    hold    = HOLD_ID;
                    state_d = INT_HOLD;
                end else if (div_start_i) begin
                    hold    = HOLD_ID;
                    state_d = DIV_WAIT;
                end else if (load_use) begin
                    hold          = HOLD_IF;
                    flush_id_ex_o = 1'b1;
                end else if (bus_hold_req_i) begin
                    hold = HOLD_PC;
                end
            end
            FLUSH: begin
                // The wrong-path fetch already in IF/ID is squashed; a fresh jump re-enters FLUSH.
                flush_if_id_o = 1'b1;
                state_d       = RUN;
                if (jump_flag_i) begin
                    jump_flag_o   = 1'b1;
                    jump_addr_o   = jump_addr_i;
                    flush_id_ex_o = 1'b1;
                    state_d       = FLUSH;
                end
            end
            DIV_WAIT: begin
                if (div_done_i) begin
                    state_d = RUN;
                end else begin
                    hold = HOLD_ID;
                end
            end
            INT_HOLD: begin
                if (int_assert_i) begin
                    jump_flag_o   = 1'b1;
                    jump_addr_o   = int_addr_i;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    state_d       = FLUSH;
                end else if (!int_hold_req_i) begin
                    state_d = RUN;
                end else begin
                    hold = HOLD_ID;
                end
            end
            default: state_d = RUN;
        endcase
        // Outputs are combinational, so reset must mask them directly to act asynchronously.
        if (!rst) begin
            state_d       = RUN;
            hold          = HOLD_NONE;
            flush_if_id_o = 1'b0;
            flush_id_ex_o = 1'b0;
            jump_flag_o   = 1'b0;
            jump_addr_o   = '0;
        end
    end

    assign hold_flag_o   = hold;
    assign stall_pc_o    = (hold >= HOLD_PC);
    assign stall_if_id_o = (hold >= HOLD_IF) && !flush_if_id_o;
    assign stall_id_ex_o = (hold >= HOLD_ID) && !flush_id_ex_o;
    assign any_stall     = stall_pc_o || stall_if_id_o || stall_id_ex_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (any_stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_cnt_q <= '0;
        end else if (jump_flag_o && (redirect_cnt_q != '1)) begin
            redirect_cnt_q <= redirect_cnt_q + REDIRECT_CNT_W'(1);
        end
    end

    assign stall_cnt_o    = stall_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;

endmodule
